// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// The loader FSM state encoding and the status bytes sent back over TX live here.
package loader_pkg;

   typedef enum logic [2:0] {
      StLen,
      StData,
      StWrite,
      StAck,
      StRun,
      StErrTx,
      StHalt
   } state_e;

   localparam logic [7:0] ACK_BYTE = 8'hAA;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream, instruction-memory write and status-byte signals of the program loader.
// master is the loader side, slave is the UART / memory side.
interface prog_loader_if #(
   parameter int unsigned ADDR_W = 12
);

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              tx_valid;
   logic [7:0]        tx_data;
   logic              tx_ready;

   modport master (
      input  rx_valid, rx_data, tx_ready,
      output rx_ready, imem_we, imem_addr, imem_wdata, tx_valid, tx_data
   );

   modport slave (
      output rx_valid, rx_data, tx_ready,
      input  rx_ready, imem_we, imem_addr, imem_wdata, tx_valid, tx_data
   );

endinterface

// File: rtl/word_assembler.sv
// Collects four accepted bytes little-endian into a 32-bit word.
// word_done_o pulses in the cycle the fourth byte is accepted.
module word_assembler (
   input  logic        clk,
   input  logic        rstn,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_done_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (byte_valid_i) begin
         cnt_d  = cnt_q + 2'd1;
         // Shift right so the first byte ends up in bits [7:0] after four bytes.
         word_d = {byte_i, word_q[31:8]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q  <= 2'd0;
         word_q <= 32'd0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign word_o      = word_q;
   assign word_done_o = byte_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// UART program loader: receives a word count and that many instruction words, writes them to
// instruction memory, acknowledges over TX and releases the core from reset.
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned ADDR_W    = 12
) (
   input  logic          clk,
   input  logic          rstn,
   prog_loader_if.master bus,
   output logic          core_rstn,
   output logic          done,
   output logic          err
);

   localparam int unsigned IDX_W = $clog2(MAX_WORDS) + 1;

   state_e            state_q, state_d;
   logic [31:0]       n_q, n_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              rx_ready_q, rx_ready_d;
   logic              rx_fire;
   logic              word_done;
   logic [31:0]       asm_word;
   logic [31:0]       full_word;
   logic [31:0]       idx_inc;

   assign rx_fire = bus.rx_valid & rx_ready_q;

   word_assembler u_word_assembler (
      .clk          (clk),
      .rstn         (rstn),
      .byte_valid_i (rx_fire),
      .byte_i       (bus.rx_data),
      .word_o       (asm_word),
      .word_done_o  (word_done)
   );

   // Complete word including the byte being accepted this cycle; only meaningful on word_done.
   assign full_word = {bus.rx_data, asm_word[31:8]};
   assign idx_inc   = 32'(idx_q) + 32'd1;

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      unique case (state_q)
         StLen: begin
            if (word_done) begin
               n_d   = full_word;
               idx_d = '0;
               if (full_word == 32'd0) begin
                  state_d = StAck;
               end else if (full_word > MAX_WORDS) begin
                  state_d = StErrTx;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (word_done) state_d = StWrite;
         end
         StWrite: begin
            idx_d   = idx_inc[IDX_W-1:0];
            state_d = (idx_inc == n_q) ? StAck : StData;
         end
         StAck: begin
            if (bus.tx_ready) state_d = StRun;
         end
         StErrTx: begin
            if (bus.tx_ready) state_d = StHalt;
         end
         StRun, StHalt: state_d = state_q;
         default: state_d = StLen;
      endcase
      // Registered so rx_ready is low in the reset cycle and drops the cycle WRITE is entered.
      rx_ready_d = (state_d == StLen) || (state_d == StData);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= StLen;
         n_q        <= 32'd0;
         idx_q      <= '0;
         rx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         rx_ready_q <= rx_ready_d;
      end
   end

   assign bus.rx_ready   = rx_ready_q;
   assign bus.imem_we    = (state_q == StWrite);
   assign bus.imem_addr  = {idx_q[ADDR_W-3:0], 2'b00};
   assign bus.imem_wdata = asm_word;
   assign bus.tx_valid   = (state_q == StAck) || (state_q == StErrTx);
   assign bus.tx_data    = (state_q == StAck)   ? ACK_BYTE :
                           (state_q == StErrTx) ? ERR_BYTE : 8'h00;
   assign core_rstn      = (state_q == StRun);
   assign done           = (state_q == StRun);
   assign err            = (state_q == StHalt);

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, instruction-memory capacity in 32-bit words.
REQ-002 Parameter ADDR_W, default 12, imem byte-address width; SHALL satisfy MAX_WORDS*4 == 2**ADDR_W.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 rx_valid  in  1  received UART byte available.
REQ-006 rx_data  in  8  received byte.
REQ-007 rx_ready  out  1  loader accepts byte; transfer when rx_valid&rx_ready.
REQ-008 imem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  out  ADDR_W  word-aligned byte address.
REQ-010 imem_wdata  out  32  instruction word.
REQ-011 tx_valid  out  1  status byte offered to UART TX.
REQ-012 tx_data  out  8  status byte.
REQ-013 tx_ready  in  1  TX accepts; transfer when tx_valid&tx_ready.
REQ-014 core_rstn  out  1  active-low reset to the core; 0 holds core in reset.
REQ-015 done  out  1  program loaded, core running.
REQ-016 err  out  1  length error, core held.

Function
REQ-017 States: LEN, DATA, WRITE, ACK, RUN, ERR_TX, HALT.
REQ-018 LEN: rx_ready=1; accept 4 bytes little-endian into word count N (32 bit).
REQ-019 After 4th LEN byte: N==0 -> ACK; N>MAX_WORDS -> ERR_TX; else -> DATA, word index idx=0.
REQ-020 DATA: rx_ready=1; accept 4 bytes little-endian; byte k lands in wdata[8k+7:8k].
REQ-021 After 4th DATA byte -> WRITE; rx_ready=0 in WRITE.
REQ-022 WRITE: imem_we=1 for exactly one cycle, imem_addr=idx*4, imem_wdata=assembled word; then idx+1; idx+1==N -> ACK, else -> DATA.
REQ-023 rx_ready SHALL be 0 in WRITE, ACK, RUN, ERR_TX, HALT; bytes arriving then are not consumed.
REQ-024 ACK: tx_valid=1, tx_data=8'hAA, held stable until tx_ready; on handshake -> RUN.
REQ-025 RUN: core_rstn=1, done=1; remain until rstn=0; no further rx consumption.
REQ-026 ERR_TX: tx_valid=1, tx_data=8'hEE until handshake -> HALT.
REQ-027 HALT: err=1, core_rstn=0; remain until rstn=0.
REQ-028 core_rstn SHALL be 0 in every state except RUN; first cycle of RUN is first cycle with core_rstn=1.
REQ-029 idx width clog2(MAX_WORDS)+1; address SHALL never wrap; max address (MAX_WORDS-1)*4.
REQ-030 All outputs registered or decoded from registered state only; no rx/tx combinational path to outputs.
REQ-031 Byte-in latency: 4th byte of word accepted in cycle t -> imem_we high in cycle t+1.

Reset
REQ-032 rstn=0 at a rising edge: state=LEN, byte count=0, idx=0, N=0, partial word discarded.
REQ-033 Reset values: rx_ready=0 during reset cycle, imem_we=0, imem_addr=0, imem_wdata=0, tx_valid=0, tx_data=0, core_rstn=0, done=0, err=0.
REQ-034 Reset in RUN SHALL drive core_rstn=0 from the next edge; new load starts at address 0.

Structure
REQ-035 Package loader_pkg SHALL hold state enum, ACK_BYTE=8'hAA, ERR_BYTE=8'hEE.
REQ-036 One sub-module word_assembler: 2-bit byte counter plus 32-bit little-endian shift register, outputs word and word_done pulse; shared by LEN and DATA.

Verification
REQ-037 N=2: bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> writes (0x000,0x00000013),(0x004,0x00100093), tx 0xAA, core_rstn=1 the cycle after handshake.
REQ-038 N=0: bytes 00 00 00 00 -> no imem_we, tx 0xAA, done=1, core_rstn=1.
REQ-039 N=1025: bytes 01 04 00 00 -> no imem_we, tx 0xEE, err=1, core_rstn stays 0; extra rx bytes not accepted.
REQ-040 N=1024 full load with random rx_valid gaps -> 1024 writes, last addr 0xFFC, no wrap, then 0xAA.
REQ-041 tx_ready low 10 cycles in ACK -> tx_valid/tx_data stable, core_rstn=0 throughout.
REQ-042 rstn pulse after 2 DATA bytes of word 1 -> state LEN; fresh N=1 load writes addr 0x000 with new word only.
